// File: rtl/ccp_tagpipe_bank_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ccp_tagpipe_bank_sched_if                                    |
// | Description : Bundle of handshake and bus signals for the CCP tag-pipe     |
// |               bank scheduler.                                              |
// |               Request side : req_valid/req_ready, req_bnk, req_set,        |
// |                              req_tag, req_id                               |
// |               Tag-RAM side : tag_rd_en (one-hot per bank), tag_rd_set      |
// |               Response side: rsp_valid, rsp_bnk, rsp_set, rsp_tag,         |
// |                              rsp_id, rsp_err                               |
// |               Status       : hazard_stall                                  |
// |               master = request producer / response consumer                |
// |               slave  = the scheduler                                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface ccp_tagpipe_bank_sched_if #(
    parameter int N_TAG_BANKS     = 2,
    parameter int MAX_TAG_BANKS   = 4,
    parameter int MAX_TAG_BANKS_W = $clog2(MAX_TAG_BANKS),
    parameter int SET_PER_BANK_W  = 9,
    parameter int TAG_W           = 17,
    parameter int ID_W            = 4
);
    logic                       req_valid;
    logic                       req_ready;
    logic [MAX_TAG_BANKS_W-1:0] req_bnk;
    logic [SET_PER_BANK_W-1:0]  req_set;
    logic [TAG_W-1:0]           req_tag;
    logic [ID_W-1:0]            req_id;

    logic [N_TAG_BANKS-1:0]     tag_rd_en;
    logic [SET_PER_BANK_W-1:0]  tag_rd_set;

    logic                       rsp_valid;
    logic [MAX_TAG_BANKS_W-1:0] rsp_bnk;
    logic [SET_PER_BANK_W-1:0]  rsp_set;
    logic [TAG_W-1:0]           rsp_tag;
    logic [ID_W-1:0]            rsp_id;
    logic                       rsp_err;

    logic                       hazard_stall;

    modport master (
        output req_valid, req_bnk, req_set, req_tag, req_id,
        input  req_ready, tag_rd_en, tag_rd_set,
        input  rsp_valid, rsp_bnk, rsp_set, rsp_tag, rsp_id, rsp_err,
        input  hazard_stall
    );

    modport slave (
        input  req_valid, req_bnk, req_set, req_tag, req_id,
        output req_ready, tag_rd_en, tag_rd_set,
        output rsp_valid, rsp_bnk, rsp_set, rsp_tag, rsp_id, rsp_err,
        output hazard_stall
    );
endinterface
`default_nettype wire

// File: rtl/ccp_tagpipe_bank_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ccp_tagpipe_bank_sched                                       |
// | Description : Tag-pipe issue stage behind the CCP address decoder. Buffers |
// |               decoded lookups in an in-order FIFO, issues at most one      |
// |               tag-RAM read per cycle, stalls the head while a read to the  |
// |               same bank/set is still in flight, and returns descriptors in |
// |               order after TAG_RD_LAT cycles.                               |
// | Ports       : clk     - clock                                              |
// |               reset_n - asynchronous active-low reset                      |
// |               bus     - slave modport of ccp_tagpipe_bank_sched_if         |
// |                         (request, tag-RAM strobe, response, hazard_stall)  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ccp_tagpipe_bank_sched #(
    parameter int N_TAG_BANKS     = 2,
    parameter int MAX_TAG_BANKS   = 4,
    parameter int MAX_TAG_BANKS_W = $clog2(MAX_TAG_BANKS),
    parameter int SET_PER_BANK_W  = 9,
    parameter int TAG_W           = 17,
    parameter int ID_W            = 4,
    parameter int FIFO_DEPTH      = 4,
    parameter int TAG_RD_LAT      = 2
) (
    input  wire logic                 clk,
    input  wire logic                 reset_n,
    ccp_tagpipe_bank_sched_if.slave   bus
);

    localparam int c_bnk_w = MAX_TAG_BANKS_W;
    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    // One extra bit so N_TAG_BANKS == MAX_TAG_BANKS is representable.
    localparam logic [c_bnk_w:0]   c_n_banks = (c_bnk_w + 1)'(N_TAG_BANKS);
    localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(FIFO_DEPTH);

    typedef struct packed {
        logic [ID_W-1:0]           id;
        logic [TAG_W-1:0]          tag;
        logic [SET_PER_BANK_W-1:0] set_idx;
        logic [c_bnk_w-1:0]        bnk;
    } entry_t;

    typedef struct packed {
        logic   valid;
        logic   err;
        entry_t ent;
    } stage_t;

    // ------------------------------------------------------------------
    // Input FIFO
    // ------------------------------------------------------------------
    entry_t             r_fifo [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    // Pipe stages 1..TAG_RD_LAT; stage TAG_RD_LAT drives the response.
    stage_t             r_pipe [1:TAG_RD_LAT];

    entry_t w_head;
    logic   w_not_empty;
    logic   w_head_err;
    logic   w_hazard;
    logic   w_issue;
    logic   w_push;
    logic   w_ready;
    logic   w_strobe;

    assign w_head      = r_fifo[r_rd_ptr];
    assign w_not_empty = (r_count != '0);
    assign w_head_err  = ({1'b0, w_head.bnk} >= c_n_banks);

    // Ready comes only from the registered count, so a full FIFO never
    // accepts in the same cycle it pops. Gated low while reset is held.
    assign w_ready  = reset_n && (r_count < c_depth);
    assign w_push   = bus.req_valid && w_ready;

    // The last stage is deliberately excluded: its read completes this
    // cycle, so a same-set lookup may issue exactly TAG_RD_LAT apart.
    always_comb begin
        w_hazard = 1'b0;
        for (int k = 1; k < TAG_RD_LAT; k++) begin
            if (r_pipe[k].valid && !r_pipe[k].err &&
                (r_pipe[k].ent.bnk == w_head.bnk) &&
                (r_pipe[k].ent.set_idx == w_head.set_idx)) begin
                w_hazard = 1'b1;
            end
        end
        // Out-of-range requests never touch a tag RAM, so never wait.
        if (w_head_err) begin
            w_hazard = 1'b0;
        end
    end

    assign w_issue  = w_not_empty && !w_hazard;
    assign w_strobe = w_issue && !w_head_err;

    // FIFO storage carries no reset; validity is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= '{id:      bus.req_id,
                                   tag:     bus.req_tag,
                                   set_idx: bus.req_set,
                                   bnk:     bus.req_bnk};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_issue})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read pipe. Empty slots are loaded as all-zero so the response
    // fields are zero whenever rsp_valid is low.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 1; k <= TAG_RD_LAT; k++) begin
                r_pipe[k] <= '0;
            end
        end else begin
            if (w_issue) begin
                r_pipe[1] <= '{valid: 1'b1, err: w_head_err, ent: w_head};
            end else begin
                r_pipe[1] <= '0;
            end
            for (int k = 2; k <= TAG_RD_LAT; k++) begin
                r_pipe[k] <= r_pipe[k-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.req_ready    = w_ready;
    assign bus.tag_rd_en    = w_strobe ? (N_TAG_BANKS'(1) << w_head.bnk) : '0;
    assign bus.tag_rd_set   = w_strobe ? w_head.set_idx : '0;
    assign bus.hazard_stall = w_not_empty && w_hazard;

    assign bus.rsp_valid    = r_pipe[TAG_RD_LAT].valid;
    assign bus.rsp_err      = r_pipe[TAG_RD_LAT].err;
    assign bus.rsp_bnk      = r_pipe[TAG_RD_LAT].ent.bnk;
    assign bus.rsp_set      = r_pipe[TAG_RD_LAT].ent.set_idx;
    assign bus.rsp_tag      = r_pipe[TAG_RD_LAT].ent.tag;
    assign bus.rsp_id       = r_pipe[TAG_RD_LAT].ent.id;

endmodule
`default_nettype wire

// File: tb/tb_ccp_tagpipe_bank_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ccp_tagpipe_bank_sched                                    |
// | Description : Self-checking bench for ccp_tagpipe_bank_sched. A queue-     |
// |               based reference model predicts every output each cycle from |
// |               issue times; scenario tasks add directed checks.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_ccp_tagpipe_bank_sched;

    localparam int NB    = 2;
    localparam int MAXB  = 4;
    localparam int BW    = 2;
    localparam int SW    = 9;
    localparam int TW    = 17;
    localparam int IW    = 4;
    localparam int DEPTH = 4;
    localparam int LAT   = 2;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    ccp_tagpipe_bank_sched_if #(
        .N_TAG_BANKS(NB), .MAX_TAG_BANKS(MAXB), .MAX_TAG_BANKS_W(BW),
        .SET_PER_BANK_W(SW), .TAG_W(TW), .ID_W(IW)
    ) bus ();

    ccp_tagpipe_bank_sched #(
        .N_TAG_BANKS(NB), .MAX_TAG_BANKS(MAXB), .MAX_TAG_BANKS_W(BW),
        .SET_PER_BANK_W(SW), .TAG_W(TW), .ID_W(IW),
        .FIFO_DEPTH(DEPTH), .TAG_RD_LAT(LAT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BW-1:0] bnk;
        logic [SW-1:0] sidx;
        logic [TW-1:0] tag;
        logic [IW-1:0] id;
    } req_t;

    typedef struct {
        int   due;
        bit   err;
        req_t r;
    } rsp_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   rsp_seen = 0;
    req_t mq[$];
    rsp_t rq[$];
    int   last_issue[int];

    logic          obs_ready, obs_hs, obs_rv, obs_rerr;
    logic [NB-1:0] obs_en;
    logic [SW-1:0] obs_set, obs_rs;
    logic [BW-1:0] obs_rb;
    logic [TW-1:0] obs_rt;
    logic [IW-1:0] obs_rid;

    // One clock cycle: drive inputs, sample outputs mid-cycle, compare with
    // the model's prediction, then advance the model.
    task automatic tick(input bit v, input logic [BW-1:0] b, input logic [SW-1:0] s,
                        input logic [TW-1:0] tg, input logic [IW-1:0] id);
        req_t          hd;
        rsp_t          rr;
        bit            herr, haz, iss, rmatch;
        int            key;
        logic          e_ready;
        logic [NB-1:0] e_en;
        logic [SW-1:0] e_set;
        req_t          nr;
        bus.req_valid = v;
        bus.req_bnk   = b;
        bus.req_set   = s;
        bus.req_tag   = tg;
        bus.req_id    = id;
        #1;
        obs_ready = bus.req_ready;  obs_en  = bus.tag_rd_en;  obs_set = bus.tag_rd_set;
        obs_hs    = bus.hazard_stall; obs_rv = bus.rsp_valid; obs_rerr = bus.rsp_err;
        obs_rb    = bus.rsp_bnk;    obs_rs  = bus.rsp_set;    obs_rt  = bus.rsp_tag;
        obs_rid   = bus.rsp_id;

        e_ready = (mq.size() < DEPTH);
        herr = 1'b0; haz = 1'b0; iss = 1'b0; key = 0;
        e_en = '0; e_set = '0;
        hd = '{bnk: '0, sidx: '0, tag: '0, id: '0};
        if (mq.size() > 0) begin
            hd   = mq[0];
            herr = (int'(hd.bnk) >= NB);
            key  = int'(hd.bnk) * 1024 + int'(hd.sidx);
            haz  = !herr && last_issue.exists(key) && ((cyc - last_issue[key]) < LAT);
            iss  = !haz;
            if (iss && !herr) begin
                e_en  = NB'(1) << hd.bnk;
                e_set = hd.sidx;
            end
        end
        rmatch = (rq.size() > 0) && (rq[0].due == cyc);
        rr = '{due: 0, err: 1'b0, r: '{bnk: '0, sidx: '0, tag: '0, id: '0}};
        if (rmatch) rr = rq[0];

        checks += 10;
        if (obs_ready !== e_ready) begin errors++; $display("FAIL ready cyc=%0d got %b exp %b", cyc, obs_ready, e_ready); end
        if (obs_en !== e_en) begin errors++; $display("FAIL tag_rd_en cyc=%0d got %b exp %b", cyc, obs_en, e_en); end
        if (obs_set !== e_set) begin errors++; $display("FAIL tag_rd_set cyc=%0d got %h exp %h", cyc, obs_set, e_set); end
        if (obs_hs !== haz) begin errors++; $display("FAIL hazard_stall cyc=%0d got %b exp %b", cyc, obs_hs, haz); end
        if (obs_rv !== rmatch) begin errors++; $display("FAIL rsp_valid cyc=%0d got %b exp %b", cyc, obs_rv, rmatch); end
        if (obs_rerr !== rr.err) begin errors++; $display("FAIL rsp_err cyc=%0d got %b exp %b", cyc, obs_rerr, rr.err); end
        if (obs_rb !== rr.r.bnk) begin errors++; $display("FAIL rsp_bnk cyc=%0d got %h exp %h", cyc, obs_rb, rr.r.bnk); end
        if (obs_rs !== rr.r.sidx) begin errors++; $display("FAIL rsp_set cyc=%0d got %h exp %h", cyc, obs_rs, rr.r.sidx); end
        if (obs_rt !== rr.r.tag) begin errors++; $display("FAIL rsp_tag cyc=%0d got %h exp %h", cyc, obs_rt, rr.r.tag); end
        if (obs_rid !== rr.r.id) begin errors++; $display("FAIL rsp_id cyc=%0d got %h exp %h", cyc, obs_rid, rr.r.id); end

        if (rmatch) void'(rq.pop_front());
        if (iss) begin
            void'(mq.pop_front());
            if (!herr) last_issue[key] = cyc;
            rq.push_back('{due: cyc + LAT, err: herr, r: hd});
        end
        if (v && e_ready) begin
            nr = '{bnk: b, sidx: s, tag: tg, id: id};
            mq.push_back(nr);
        end
        if (obs_rv === 1'b1) rsp_seen++;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle();
        tick(1'b0, '0, '0, '0, '0);
    endtask

    task automatic drain();
        repeat (12) idle();
    endtask

    // Assert reset at a mid-cycle point; outputs must clear at once.
    task automatic apply_reset();
        bus.req_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        checks += 2;
        if (bus.req_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready got %b exp 0", bus.req_ready);
        end
        if ({bus.tag_rd_en, bus.tag_rd_set, bus.hazard_stall, bus.rsp_valid, bus.rsp_bnk,
             bus.rsp_set, bus.rsp_tag, bus.rsp_id, bus.rsp_err} !== '0) begin
            errors++; $display("FAIL reset_outputs got en=%b rv=%b hs=%b exp all 0",
                               bus.tag_rd_en, bus.rsp_valid, bus.hazard_stall);
        end
        mq.delete();
        rq.delete();
        last_issue.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        @(negedge clk);
        apply_reset();
        idle();
        checks++;
        if (obs_ready !== 1'b1) begin errors++; $display("FAIL ready_after_release got %b exp 1", obs_ready); end
    endtask

    task automatic test_single();
        tick(1'b1, 2'd1, 9'h005, 17'h1ABCD, 4'd3);
        idle();
        checks += 2;
        if (obs_en !== 2'b10) begin errors++; $display("FAIL single_en got %b exp 10", obs_en); end
        if (obs_set !== 9'h005) begin errors++; $display("FAIL single_set got %h exp 005", obs_set); end
        idle();
        idle();
        checks += 4;
        if (obs_rv !== 1'b1) begin errors++; $display("FAIL single_rv got %b exp 1", obs_rv); end
        if (obs_rt !== 17'h1ABCD) begin errors++; $display("FAIL single_tag got %h exp 1abcd", obs_rt); end
        if (obs_rid !== 4'd3) begin errors++; $display("FAIL single_id got %0d exp 3", obs_rid); end
        if (obs_rerr !== 1'b0) begin errors++; $display("FAIL single_err got %b exp 0", obs_rerr); end
        drain();
    endtask

    task automatic test_back_to_back();
        tick(1'b1, 2'd0, 9'h010, 17'h00111, 4'd1);
        tick(1'b1, 2'd0, 9'h010, 17'h00222, 4'd2);
        checks++;
        if (obs_en !== 2'b01) begin errors++; $display("FAIL b2b_issue1 got %b exp 01", obs_en); end
        idle();
        checks += 2;
        if (obs_hs !== 1'b1) begin errors++; $display("FAIL b2b_stall got %b exp 1", obs_hs); end
        if (obs_en !== 2'b00) begin errors++; $display("FAIL b2b_stall_en got %b exp 00", obs_en); end
        idle();
        checks += 2;
        if (obs_en !== 2'b01) begin errors++; $display("FAIL b2b_issue2 got %b exp 01", obs_en); end
        if (obs_rv !== 1'b1 || obs_rid !== 4'd1) begin errors++; $display("FAIL b2b_rsp1 got rv=%b id=%0d exp rv=1 id=1", obs_rv, obs_rid); end
        idle();
        idle();
        checks++;
        if (obs_rv !== 1'b1 || obs_rid !== 4'd2) begin errors++; $display("FAIL b2b_rsp2 got rv=%b id=%0d exp rv=1 id=2", obs_rv, obs_rid); end
        drain();
    endtask

    task automatic test_alternate();
        for (int i = 0; i < 8; i++) begin
            if (i < 4) tick(1'b1, BW'(i % 2), SW'(9'h040 + i), TW'(i * 7), IW'(4 + i));
            else idle();
            if (i >= 1 && i <= 4) begin
                checks += 2;
                if (obs_en !== (NB'(1) << ((i - 1) % 2))) begin errors++; $display("FAIL alt_en i=%0d got %b", i, obs_en); end
                if (obs_hs !== 1'b0) begin errors++; $display("FAIL alt_stall i=%0d got %b exp 0", i, obs_hs); end
            end
            if (i >= 3 && i <= 6) begin
                checks++;
                if (obs_rv !== 1'b1 || obs_rid !== IW'(i + 1)) begin
                    errors++; $display("FAIL alt_rsp i=%0d got rv=%b id=%0d exp id=%0d", i, obs_rv, obs_rid, i + 1);
                end
            end
        end
        drain();
    endtask

    task automatic test_full();
        int next_id  = 0;
        int accepted = 0;
        int base;
        bit saw_full = 1'b0;
        bit reopened = 1'b0;
        base = rsp_seen;
        for (int i = 0; i < 16; i++) begin
            tick(1'b1, 2'd0, 9'h033, TW'(i), IW'(next_id));
            if (obs_ready === 1'b1) begin
                if (saw_full) reopened = 1'b1;
                accepted++;
                next_id++;
            end else begin
                saw_full = 1'b1;
            end
        end
        drain();
        checks += 3;
        if (saw_full !== 1'b1) begin errors++; $display("FAIL full_ready_low got %b exp 1", saw_full); end
        if (reopened !== 1'b1) begin errors++; $display("FAIL full_reopen got %b exp 1", reopened); end
        if ((rsp_seen - base) !== accepted) begin
            errors++; $display("FAIL full_rsp_count got %0d exp %0d", rsp_seen - base, accepted);
        end
    endtask

    task automatic test_err();
        tick(1'b1, 2'd3, 9'h077, 17'h0BEEF, 4'd8);
        tick(1'b1, 2'd0, 9'h078, 17'h0CAFE, 4'd9);
        checks += 2;
        if (obs_en !== 2'b00) begin errors++; $display("FAIL err_no_strobe got %b exp 00", obs_en); end
        if (obs_hs !== 1'b0) begin errors++; $display("FAIL err_no_stall got %b exp 0", obs_hs); end
        idle();
        checks++;
        if (obs_en !== 2'b01) begin errors++; $display("FAIL err_next_issue got %b exp 01", obs_en); end
        idle();
        checks++;
        if (obs_rv !== 1'b1 || obs_rerr !== 1'b1 || obs_rid !== 4'd8) begin
            errors++; $display("FAIL err_rsp got rv=%b err=%b id=%0d exp 1 1 8", obs_rv, obs_rerr, obs_rid);
        end
        idle();
        checks++;
        if (obs_rv !== 1'b1 || obs_rerr !== 1'b0 || obs_rid !== 4'd9) begin
            errors++; $display("FAIL err_rsp2 got rv=%b err=%b id=%0d exp 1 0 9", obs_rv, obs_rerr, obs_rid);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        bit any_rv = 1'b0;
        tick(1'b1, 2'd1, 9'h020, 17'h00010, 4'd10);
        tick(1'b1, 2'd1, 9'h020, 17'h00011, 4'd11);
        tick(1'b1, 2'd1, 9'h020, 17'h00012, 4'd12);
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            idle();
            if (obs_rv !== 1'b0) any_rv = 1'b1;
        end
        checks++;
        if (any_rv !== 1'b0) begin errors++; $display("FAIL reset_mid_stale_rsp got %b exp 0", any_rv); end
        tick(1'b1, 2'd0, 9'h021, 17'h00013, 4'd13);
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(0, 9) < 7, BW'($urandom_range(0, 3)), SW'($urandom_range(0, 3)),
                 TW'($urandom), IW'($urandom));
        end
        drain();
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_bnk   = '0;
        bus.req_set   = '0;
        bus.req_tag   = '0;
        bus.req_id    = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_alternate();
        test_full();
        test_err();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ccp_tagpipe_bank_sched.md
Name: ccp_tagpipe_bank_sched

Overview:
Tag-pipe issue stage directly downstream of the CCP address-to-index decoder. It accepts decoded lookups (bank, set, tag, id) over a valid/ready handshake and buffers them in a small in-order FIFO. It issues at most one tag-RAM read per cycle to the selected bank, stalling on same-bank/same-set hazards with reads still in flight. Lookup descriptors are returned in order after the fixed tag-RAM read latency.

Parameters:
N_TAG_BANKS, 2, number of tag banks (1..MAX_TAG_BANKS)
MAX_TAG_BANKS, 4, architectural maximum bank count
MAX_TAG_BANKS_W, $clog2(MAX_TAG_BANKS), bank-number width
SET_PER_BANK_W, 9, set index width within a bank
TAG_W, 17, tag width
ID_W, 4, request id width
FIFO_DEPTH, 4, input FIFO entries (power of 2, >=2)
TAG_RD_LAT, 2, tag-RAM read latency in cycles (>=1)

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
req_valid  input  1  lookup request valid
req_ready  output  1  FIFO can accept
req_bnk  input  MAX_TAG_BANKS_W  decoded bank number
req_set  input  SET_PER_BANK_W  decoded set within bank
req_tag  input  TAG_W  decoded tag
req_id  input  ID_W  request id
tag_rd_en  output  N_TAG_BANKS  one-hot per-bank read strobe
tag_rd_set  output  SET_PER_BANK_W  set index for the strobed bank
rsp_valid  output  1  lookup descriptor valid (no backpressure)
rsp_bnk  output  MAX_TAG_BANKS_W  bank of returned lookup
rsp_set  output  SET_PER_BANK_W  set of returned lookup
rsp_tag  output  TAG_W  tag of returned lookup
rsp_id  output  ID_W  id of returned lookup
rsp_err  output  1  request named an out-of-range bank
hazard_stall  output  1  head blocked by set hazard this cycle

Behaviour:
- Reset (async assert, sync deassert to clk): FIFO empty; all pipe stages invalid; req_ready=0 while reset_n=0 and 1 on the first cycle after release; all other outputs 0.
- FIFO: push when req_valid && req_ready. req_ready = (count < FIFO_DEPTH), derived from registered count, so no same-cycle push-through at full. Pop on issue. Simultaneous push and pop when not full keeps count unchanged. A pushed entry becomes head no earlier than the next cycle. Pointers wrap modulo FIFO_DEPTH.
- Pipe: stages s[1..TAG_RD_LAT], each holding {valid, bnk, set, tag, id, err}. Stage s[1] loads the entry issued in the previous cycle; s[k] loads s[k-1] every cycle.
- Issue condition at cycle t: FIFO not empty and no hazard.
  - Hazard: head err=0 and any valid s[k], k in 1..TAG_RD_LAT-1, with err=0 and equal bnk and equal set.
  - Stage s[TAG_RD_LAT] is not compared, so same-set lookups issue exactly TAG_RD_LAT cycles apart.
  - Same bank with a different set, or a different bank, never stalls.
- On issue:
  - err = (head bnk >= N_TAG_BANKS).
  - If err=0: tag_rd_en[bnk]=1 and tag_rd_set=set in cycle t (combinational from the registered head).
  - If err=1: no strobe; the entry still enters s[1].
- No issue: tag_rd_en=0, tag_rd_set=0. s[1] loads invalid.
- hazard_stall = FIFO not empty && hazard. Asserted every blocked cycle.
- Response: rsp_* driven from s[TAG_RD_LAT], so rsp_valid rises at t+TAG_RD_LAT for an issue at t. Output fields are 0 when rsp_valid=0.
- Ordering: strictly in order. The hazard blocks the whole FIFO; there is no bypass.
- Throughput: one issue per cycle when there are no hazards.
- Reset mid-operation: in-flight reads and FIFO contents are discarded. No rsp_valid is produced for them.

Test Plan:
- Reset release, single request bnk=1 set=0x05 tag=0x1ABCD id=3 at cycle 0 -> head at cycle 1, tag_rd_en=2'b10 and tag_rd_set=0x05 at cycle 1; rsp_valid=1 at cycle 3 with the same fields and rsp_err=0.
- Back-to-back bnk=0 set=0x10 id=1 then bnk=0 set=0x10 id=2 -> id1 issues at cycle c, hazard_stall=1 at c+1, id2 issues at c+2; responses at c+2 and c+4.
- Four requests alternating bnk 0/1 with distinct sets -> one strobe per cycle with no stall; responses on four consecutive cycles in id order.
- Hold req_valid with no issue possible (a hazard chain) until FIFO has 4 entries -> req_ready=0. After one pop, req_ready=1 next cycle and no request is lost or duplicated.
- Request with bnk=3 and N_TAG_BANKS=2 -> tag_rd_en=0 in its issue cycle; rsp_valid with rsp_err=1 TAG_RD_LAT cycles later; a following bnk=0 request is not delayed.
- Assert reset_n=0 with 2 entries in the FIFO and 1 in the pipe -> all outputs 0 immediately; after release, no rsp_valid until new requests arrive.
